// File: rtl/fcpu_pkg.sv
// Shared CPU types: common data bus entry layout and arbiter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fcpu_pkg;

  localparam int RSV_ID_W      = 6;
  localparam int DATA_W        = 32;
  localparam int CDB_W         = RSV_ID_W + DATA_W;
  localparam int CDB_ARB_UNITS = 4;

  // rob_id sits in the upper bits, matching the flat u_data/cdb slices.
  typedef struct packed {
    logic [RSV_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_unit_queue.sv
// Per-unit result queue feeding the CDB arbiter.
// Latency: entry written at an edge is visible at head after that edge.
// Backpressure: ready drops when full (no same-cycle pass-through); held low in reset.
// Ports: clk, rst (async, active-high), flush (sync clear), push/push_data/ready,
//        pop/head/empty, count (registered occupancy).
module cdb_unit_queue
  import fcpu_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  cdb_entry_t                   push_data,
  output logic                         ready,
  input  logic                         pop,
  output cdb_entry_t                   head,
  output logic                         empty,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  cdb_entry_t     mem [QDEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from the registered count only, so a full queue stays
  // not-ready even in a cycle where it is being popped.
  assign ready   = (count < CW'(QDEPTH)) & ~rst;
  assign empty   = (count == '0);
  assign push_ok = push & ready;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin sharing of the common data bus among N_UNITS result queues.
// Latency: push at edge t appears on cdb after edge t+1 when uncontended; 1 result/cycle.
// Backpressure: per-unit u_ready from queue occupancy; CDB itself is never stalled.
// Ports: clk, rst (async, active-high), flush, u_valid/u_data/u_ready per unit,
//        cdb_valid/cdb/cdb_grant (registered broadcast), busy (any queue non-empty).
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter int N_UNITS = CDB_ARB_UNITS,
  parameter int QDEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [N_UNITS-1:0]            u_valid,
  input  logic [N_UNITS*CDB_W-1:0]      u_data,
  output logic [N_UNITS-1:0]            u_ready,
  output logic                          cdb_valid,
  output logic [CDB_W-1:0]              cdb,
  output logic [$clog2(N_UNITS)-1:0]    cdb_grant,
  output logic                          busy
);

  localparam int GW = $clog2(N_UNITS);
  localparam int CW = $clog2(QDEPTH + 1);

  if ($bits(cdb_entry_t) != CDB_W) begin : g_width_check
    $error("cdb_entry_t width does not match CDB_W");
  end

  cdb_entry_t          heads [N_UNITS];
  logic [CW-1:0]       counts [N_UNITS];
  logic [N_UNITS-1:0]  empty;
  logic [N_UNITS-1:0]  req;
  logic [N_UNITS-1:0]  pop;
  logic [GW-1:0]       rr_ptr;
  logic                win_vld;
  logic [GW-1:0]       win_idx;

  // Rotate requests so rr_ptr lands at bit 0, take the lowest set bit,
  // then map the offset back to an absolute unit index (mod N_UNITS).
  function automatic logic [GW:0] rr_pick(input logic [N_UNITS-1:0] r,
                                          input logic [GW-1:0]      ptr);
    logic [2*N_UNITS-1:0] dbl;
    logic [N_UNITS-1:0]   rot;
    logic                 found;
    logic [GW:0]          off;
    logic [GW:0]          sum;
    dbl   = {r, r} >> ptr;
    rot   = dbl[N_UNITS-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = N_UNITS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = (GW + 1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (GW + 1)'(N_UNITS)) sum = sum - (GW + 1)'(N_UNITS);
    return {found, sum[GW-1:0]};
  endfunction

  for (genvar i = 0; i < N_UNITS; i++) begin : g_q
    cdb_unit_queue #(.QDEPTH(QDEPTH)) u_q (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (u_valid[i] & ~flush),
      .push_data (u_data[i*CDB_W +: CDB_W]),
      .ready     (u_ready[i]),
      .pop       (pop[i]),
      .head      (heads[i]),
      .empty     (empty[i]),
      .count     (counts[i])
    );
  end

  assign req = ~empty;

  always_comb begin
    {win_vld, win_idx} = rr_pick(req, rr_ptr);
    pop  = '0;
    busy = 1'b0;
    for (int i = 0; i < N_UNITS; i++) begin
      pop[i] = win_vld & (win_idx == GW'(i)) & ~flush;
      busy   = busy | (counts[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb       <= '0;
      cdb_grant <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      // cdb/cdb_grant intentionally hold; only the valid is killed.
      cdb_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (win_vld) begin
      cdb_valid <= 1'b1;
      cdb       <= heads[win_idx];
      cdb_grant <= win_idx;
      rr_ptr    <= (win_idx == GW'(N_UNITS - 1)) ? '0 : win_idx + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (N_UNITS=4, QDEPTH=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  localparam int N = 4;
  localparam int Q = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [N-1:0]         u_valid;
  logic [N*CDB_W-1:0]   u_data;
  logic [N-1:0]         u_ready;
  logic                 cdb_valid;
  logic [CDB_W-1:0]     cdb;
  logic [1:0]           cdb_grant;
  logic                 busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [CDB_W-1:0] sb0[$];
  logic [CDB_W-1:0] sb3[$];

  always #5 clk = ~clk;

  cdb_arbiter #(.N_UNITS(N), .QDEPTH(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .u_valid   (u_valid),
    .u_data    (u_data),
    .u_ready   (u_ready),
    .cdb_valid (cdb_valid),
    .cdb       (cdb),
    .cdb_grant (cdb_grant),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [CDB_W-1:0] ent(input logic [RSV_ID_W-1:0] rob,
                                           input logic [DATA_W-1:0] d);
    return {rob, d};
  endfunction

  task automatic drive(input int u, input logic [CDB_W-1:0] v);
    u_valid[u] = 1'b1;
    u_data[u*CDB_W +: CDB_W] = v;
  endtask

  task automatic idle();
    u_valid = '0;
    u_data  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check();
    if (cdb_valid) begin
      if (cdb_grant == 2'd0 && sb0.size() > 0)      chk("t3_data_u0", cdb, sb0.pop_front());
      else if (cdb_grant == 2'd3 && sb3.size() > 0) chk("t3_data_u3", cdb, sb3.pop_front());
      else                                          chk("t3_unexpected_grant", {62'd0, cdb_grant}, 64'hff);
    end
  endtask

  initial begin
    logic [N-1:0] r;
    int seq0, seq3;
    logic rdy0_low, rdy3_low;

    rst = 1'b1; flush = 1'b0; idle();

    // Reset state
    tick();
    chk("rst_ready", u_ready, 4'h0);
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_cdb",   cdb, '0);
    chk("rst_grant", cdb_grant, 2'd0);
    chk("rst_busy",  busy, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", u_ready, 4'hf);

    // 1: single uncontended push from unit 2
    drive(2, ent(6'd5, 32'hDEADBEEF));
    tick(); idle();
    chk("t1_busy_t",   busy, 1'b1);
    chk("t1_valid_t",  cdb_valid, 1'b0);
    tick();
    chk("t1_valid",    cdb_valid, 1'b1);
    chk("t1_cdb",      cdb, ent(6'd5, 32'hDEADBEEF));
    chk("t1_grant",    cdb_grant, 2'd2);
    chk("t1_busy_off", busy, 1'b0);
    tick();
    chk("t1_valid_off", cdb_valid, 1'b0);
    chk("t1_cdb_hold",  cdb, ent(6'd5, 32'hDEADBEEF));

    // 2: all four push together from rr_ptr=0
    flush = 1'b1; tick(); flush = 1'b0;
    for (int u = 0; u < N; u++) drive(u, ent(RSV_ID_W'(u + 1), 32'h100 + u));
    tick(); idle();
    for (int k = 0; k < N; k++) begin
      tick();
      chk("t2_valid", cdb_valid, 1'b1);
      chk("t2_grant", cdb_grant, 64'(k));
      chk("t2_cdb",   cdb, ent(RSV_ID_W'(k + 1), 32'h100 + k));
    end
    tick();
    chk("t2_valid_end", cdb_valid, 1'b0);

    // 3: units 0 and 3 stream; rr_ptr wrapped back to 0
    seq0 = 0; seq3 = 0; rdy0_low = 1'b0; rdy3_low = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      drive(0, ent(6'd1, 32'hA000 + seq0));
      drive(3, ent(6'd3, 32'hB000 + seq3));
      r = u_ready;
      if (r[0]) begin sb0.push_back(ent(6'd1, 32'hA000 + seq0)); seq0++; end
      else rdy0_low = 1'b1;
      if (r[3]) begin sb3.push_back(ent(6'd3, 32'hB000 + seq3)); seq3++; end
      else rdy3_low = 1'b1;
      tick();
      if (c == 1) chk("t3_first_valid", cdb_valid, 1'b0);
      else begin
        chk("t3_valid", cdb_valid, 1'b1);
        chk("t3_alt_grant", cdb_grant, (c % 2 == 0) ? 2'd0 : 2'd3);
      end
      sb_check();
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      tick();
      sb_check();
    end
    chk("t3_sb0_empty", sb0.size(), 0);
    chk("t3_sb3_empty", sb3.size(), 0);
    chk("t3_rdy0_dropped", rdy0_low, 1'b1);
    chk("t3_rdy3_dropped", rdy3_low, 1'b1);
    chk("t3_busy_end", busy, 1'b0);

    // 4: flush with queues at 0/2/1/2 and a same-cycle handshake
    flush = 1'b1; tick(); flush = 1'b0;
    drive(1, ent(6'd1, 32'hA1));
    tick(); idle();
    drive(1, ent(6'd1, 32'hB1)); drive(2, ent(6'd2, 32'hB2)); drive(3, ent(6'd3, 32'hB3));
    tick(); idle();
    chk("t4_b_grant", cdb_grant, 2'd1);
    chk("t4_b_cdb",   cdb, ent(6'd1, 32'hA1));
    drive(1, ent(6'd1, 32'hC1)); drive(2, ent(6'd2, 32'hC2)); drive(3, ent(6'd3, 32'hC3));
    tick(); idle();
    chk("t4_c_grant", cdb_grant, 2'd2);
    chk("t4_c_cdb",   cdb, ent(6'd2, 32'hB2));
    chk("t4_pre_ready", u_ready, 4'b0101);
    chk("t4_pre_busy",  busy, 1'b1);
    flush = 1'b1;
    drive(0, ent(6'd0, 32'hF0)); drive(2, ent(6'd2, 32'hF2));
    tick(); flush = 1'b0; idle();
    chk("t4_valid",      cdb_valid, 1'b0);
    chk("t4_busy",       busy, 1'b0);
    chk("t4_ready",      u_ready, 4'hf);
    chk("t4_cdb_hold",   cdb, ent(6'd2, 32'hB2));
    chk("t4_grant_hold", cdb_grant, 2'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_no_stale", cdb_valid, 1'b0);
    end
    drive(3, ent(6'd3, 32'hD3));
    tick(); idle();
    chk("t4_u3_lat", cdb_valid, 1'b0);
    tick();
    chk("t4_u3_valid", cdb_valid, 1'b1);
    chk("t4_u3_grant", cdb_grant, 2'd3);
    chk("t4_u3_cdb",   cdb, ent(6'd3, 32'hD3));

    // 5: asynchronous reset mid-stream
    drive(0, ent(6'd0, 32'hE0)); drive(1, ent(6'd1, 32'hE1));
    tick(); idle();
    tick();
    chk("t5_pre_valid", cdb_valid, 1'b1);
    chk("t5_pre_grant", cdb_grant, 2'd0);
    rst = 1'b1;
    #2;
    chk("t5_async_valid", cdb_valid, 1'b0);
    chk("t5_async_ready", u_ready, 4'h0);
    chk("t5_async_busy",  busy, 1'b0);
    chk("t5_async_cdb",   cdb, '0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_rel_ready", u_ready, 4'hf);
    drive(1, ent(6'd1, 32'h61));
    tick(); idle();
    chk("t5_lat_valid", cdb_valid, 1'b0);
    chk("t5_lat_busy",  busy, 1'b1);
    tick();
    chk("t5_valid", cdb_valid, 1'b1);
    chk("t5_grant", cdb_grant, 2'd1);
    chk("t5_cdb",   cdb, ent(6'd1, 32'h61));

    // 6: full queue 1 selected while unit 1 keeps pushing
    drive(0, ent(6'd0, 32'h70)); drive(1, ent(6'd1, 32'h80));
    tick(); idle();
    drive(1, ent(6'd1, 32'h81));
    tick();
    chk("t6_b_grant", cdb_grant, 2'd0);
    chk("t6_b_cdb",   cdb, ent(6'd0, 32'h70));
    drive(1, ent(6'd1, 32'h82));
    chk("t6_full_not_ready", u_ready[1], 1'b0);
    tick();
    chk("t6_c_grant", cdb_grant, 2'd1);
    chk("t6_c_cdb",   cdb, ent(6'd1, 32'h80));
    chk("t6_ready_again", u_ready[1], 1'b1);
    tick(); idle();
    chk("t6_d_cdb",   cdb, ent(6'd1, 32'h81));
    tick();
    chk("t6_e_valid", cdb_valid, 1'b1);
    chk("t6_e_cdb",   cdb, ent(6'd1, 32'h82));
    tick();
    chk("t6_f_valid", cdb_valid, 1'b0);
    chk("t6_f_busy",  busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
